// File: rtl/spike_window_pkg.sv
// Shared types and helpers for the spike window counter.
// Build option: SPIKE_WINDOW_SKID_EN selects a 2-entry result FIFO
// instead of the single result register (see spike_result_buf).
package spike_window_pkg;

    // Default widths of the spike count and of the window length.
    localparam int unsigned CNT_WIDTH_DEFAULT = 16;
    localparam int unsigned WIN_WIDTH_DEFAULT = 16;

    // Widest count the saturating helper can handle.
    localparam int unsigned SAT_MAX_WIDTH = 32;

    // Window FSM: idle between windows, counting inside a window.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Saturating increment of a value that is 'width' bits wide.
    // The value is passed zero-extended to 32 bits; the result clamps at
    // 2^width-1 and never wraps.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
        input logic [SAT_MAX_WIDTH-1:0] value,
        input logic                     inc,
        input int unsigned              width
    );
        logic [SAT_MAX_WIDTH-1:0] max_val;
        if (width >= SAT_MAX_WIDTH) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        if (inc && (value < max_val)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/spike_result_buf.sv
// Output buffer for completed window counts, presented as a valid/ready
// stream. Default build: one result register. With SPIKE_WINDOW_SKID_EN
// defined: a 2-entry FIFO whose head is always on data_o.
// drop_o pulses on an edge where a push finds no room.
module spike_result_buf
    import spike_window_pkg::*;
#(
    parameter int unsigned W = CNT_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

`ifdef SPIKE_WINDOW_SKID_EN

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   fill_q;
    logic         pop;

    // A pop needs an occupied head; a drop needs a full FIFO with no pop.
    always_comb begin
        pop     = (fill_q != 2'd0) && ready_i;
        valid_o = (fill_q != 2'd0);
        data_o  = head_q;
        drop_o  = push_i && !pop && (fill_q == 2'd2);
    end

    // FIFO storage: head is the oldest entry, tail the second one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    case (fill_q)
                        2'd0: begin
                            head_q <= data_i;
                            fill_q <= 2'd1;
                        end
                        2'd1: begin
                            tail_q <= data_i;
                            fill_q <= 2'd2;
                        end
                        default: begin
                            // Full: the new result is discarded (drop_o).
                        end
                    endcase
                end
                2'b01: begin
                    if (fill_q == 2'd2) begin
                        head_q <= tail_q;
                    end
                    fill_q <= fill_q - 2'd1;
                end
                2'b11: begin
                    // Fill level is unchanged; the queue shifts by one.
                    if (fill_q == 2'd1) begin
                        head_q <= data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`else

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         pop;

    // A full register accepts a new result only if the old one leaves now.
    always_comb begin
        pop     = valid_q && ready_i;
        valid_o = valid_q;
        data_o  = data_q;
        drop_o  = push_i && valid_q && !ready_i;
    end

    // Single result register; data is held while waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_i && (!valid_q || pop)) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/spike_window_counter.sv
// Counts neuron spikes over a programmable window of win_len clock cycles
// and emits one saturating count per window on a valid/ready stream.
// Results that find the output buffer full are discarded and recorded in
// the sticky 'dropped' flag.
// Build option: SPIKE_WINDOW_SKID_EN gives the output a 2-entry FIFO.
module spike_window_counter
    import spike_window_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
    parameter int unsigned WIN_WIDTH = WIN_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spike_in,
    input  logic                 enable,
    input  logic [WIN_WIDTH-1:0] win_len,
    output logic [CNT_WIDTH-1:0] count_data,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 dropped
);

    state_e               state_q;
    logic [WIN_WIDTH-1:0] cyc_q;
    logic [CNT_WIDTH-1:0] spk_q;
    logic                 dropped_q;

    logic [CNT_WIDTH-1:0] spk_d;
    logic                 start_ok;
    logic                 last_edge;
    logic                 buf_drop;

    // Saturated running count including this edge's spike, window-start
    // condition, and detection of the last edge of the window.
    always_comb begin
        spk_d     = CNT_WIDTH'(sat_inc(32'(spk_q), spike_in, CNT_WIDTH));
        start_ok  = enable && (win_len != '0);
        last_edge = (state_q == COUNT) && (cyc_q == '0);
    end

    // Window FSM: cyc counts remaining edges down to 0, spk accumulates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            spk_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // spike_in is ignored while idle.
                    if (start_ok) begin
                        state_q <= COUNT;
                        cyc_q   <= win_len - WIN_WIDTH'(1);
                        spk_q   <= '0;
                    end
                end
                COUNT: begin
                    if (cyc_q == '0) begin
                        // Result spk_d is pushed this edge; restart back to
                        // back if a new window may start, else go idle.
                        if (start_ok) begin
                            cyc_q <= win_len - WIN_WIDTH'(1);
                            spk_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            spk_q   <= '0;
                        end
                    end else if (!enable) begin
                        // Abort: partial count is thrown away.
                        state_q <= IDLE;
                        cyc_q   <= '0;
                        spk_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q - WIN_WIDTH'(1);
                        spk_q <= spk_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= '0;
                    spk_q   <= '0;
                end
            endcase
        end
    end

    // Sticky record of any result lost to a full output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dropped_q <= 1'b0;
        end else if (buf_drop) begin
            dropped_q <= 1'b1;
        end
    end

    assign dropped = dropped_q;

    spike_result_buf #(
        .W(CNT_WIDTH)
    ) u_result_buf (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (last_edge),
        .data_i  (spk_d),
        .valid_o (count_valid),
        .ready_i (count_ready),
        .data_o  (count_data),
        .drop_o  (buf_drop)
    );

endmodule

// File: tb/tb_spike_window_counter.sv
// Self-checking bench for spike_window_counter (4-bit count so saturation
// is reachable). Works for both builds; SPIKE_WINDOW_SKID_EN changes the
// expected buffer depth.
module tb_spike_window_counter;

    localparam int CW   = 4;
    localparam int WW   = 8;
    localparam int MAXV = (1 << CW) - 1;
`ifdef SPIKE_WINDOW_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          spike_in = 1'b0;
    logic          enable = 1'b0;
    logic [WW-1:0] win_len = '0;
    logic          count_ready = 1'b0;
    logic [CW-1:0] count_data;
    logic          count_valid;
    logic          dropped;

    int vectors = 0;
    int miscompares = 0;

    spike_window_counter #(
        .CNT_WIDTH(CW),
        .WIN_WIDTH(WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (spike_in),
        .enable      (enable),
        .win_len     (win_len),
        .count_data  (count_data),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    // Reference model: a window is "edges still to go" plus an unbounded
    // spike tally; finished results go into a bounded queue.
    bit m_active;
    int m_remaining;
    int m_count;
    int m_q[$];
    bit m_dropped;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_remaining = 0;
        m_count     = 0;
        m_q.delete();
        m_dropped   = 0;
    endtask

    task automatic model_edge(input bit s, input bit e, input int wl, input bit r);
        bit pop;
        bit do_push;
        int res;
        pop     = (m_q.size() > 0) && r;
        do_push = 0;
        res     = 0;
        if (!m_active) begin
            if (e && wl != 0) begin
                m_active    = 1;
                m_remaining = wl;
                m_count     = 0;
            end
        end else begin
            m_remaining = m_remaining - 1;
            m_count     = m_count + int'(s);
            if (m_remaining == 0) begin
                do_push = 1;
                res     = (m_count > MAXV) ? MAXV : m_count;
                if (e && wl != 0) begin
                    m_remaining = wl;
                    m_count     = 0;
                end else begin
                    m_active = 0;
                end
            end else if (!e) begin
                m_active = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(res);
            else m_dropped = 1;
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare against the model.
    task automatic step(input logic s, input logic e, input int wl, input logic r);
        spike_in    = s;
        enable      = e;
        win_len     = WW'(wl);
        count_ready = r;
        @(posedge clk);
        model_edge(s, e, wl, r);
        #1;
        check("model_valid", count_valid, (m_q.size() > 0) ? 1 : 0);
        check("model_dropped", dropped, int'(m_dropped));
        if (m_q.size() > 0) check("model_data", count_data, m_q[0]);
    endtask

    typedef struct {
        logic spike;
        logic en;
        int   wl;
        logic rdy;
        logic exp_valid;
        int   exp_data;
        logic exp_dropped;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // Basic count: entry on row 0, window edges rows 1..8 with spikes on
        // window edges 2, 3, 7; second window rows 9..16 silent; row 17 aborts.
        for (int i = 0; i < 19; i++) begin
            tbl[i].spike       = (i == 2) || (i == 3) || (i == 7);
            tbl[i].en          = (i < 17);
            tbl[i].wl          = 8;
            tbl[i].rdy         = 1'b1;
            tbl[i].exp_valid   = 1'b0;
            tbl[i].exp_data    = 0;
            tbl[i].exp_dropped = 1'b0;
        end
        tbl[8].exp_valid  = 1'b1;
        tbl[8].exp_data   = 3;
        tbl[16].exp_valid = 1'b1;
        tbl[16].exp_data  = 0;

        // Reset held with activity on the inputs.
        rst = 1'b0; spike_in = 1'b1; enable = 1'b1; win_len = WW'(5); count_ready = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_valid", count_valid, 0);
            check("rst_data", count_data, 0);
            check("rst_dropped", dropped, 0);
        end
        rst = 1'b1;

        // Table-driven basic count.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].spike, tbl[i].en, tbl[i].wl, tbl[i].rdy);
            check("tbl_valid", count_valid, int'(tbl[i].exp_valid));
            check("tbl_dropped", dropped, int'(tbl[i].exp_dropped));
            if (tbl[i].exp_valid) check("tbl_data", count_data, tbl[i].exp_data);
        end

        // Saturation: 20 spikes into a 4-bit counter clamp at 15.
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 20, 1'b1);
        check("sat_valid", count_valid, 1);
        check("sat_data", count_data, MAXV);
        repeat (2) step(1'b0, 1'b0, 20, 1'b1);

        // Abort after 5 window edges, then a fresh 4-edge window with 3 spikes.
        step(1'b0, 1'b1, 10, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 10, 1'b1);
        step(1'b1, 1'b0, 10, 1'b1);
        check("abort_valid", count_valid, 0);
        repeat (2) begin
            step(1'b1, 1'b0, 10, 1'b1);
            check("abort_idle_valid", count_valid, 0);
        end
        step(1'b0, 1'b1, 4, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4, 1'b1);
        step(1'b0, 1'b0, 4, 1'b1);
        check("reenable_valid", count_valid, 1);
        check("reenable_data", count_data, 3);
        step(1'b0, 1'b0, 4, 1'b1);

        // Backpressure: three results of 2 with the consumer stalled.
        step(1'b0, 1'b1, 2, 1'b0);
        repeat (2) step(1'b1, 1'b1, 2, 1'b0);
        check("bp_first_valid", count_valid, 1);
        check("bp_first_data", count_data, 2);
        check("bp_first_dropped", dropped, 0);
        repeat (2) step(1'b1, 1'b1, 2, 1'b0);
        check("bp_second_dropped", dropped, (DEPTH == 1) ? 1 : 0);
        check("bp_second_data", count_data, 2);
        step(1'b1, 1'b1, 2, 1'b0);
        step(1'b1, 1'b0, 2, 1'b0);
        check("bp_third_dropped", dropped, 1);
        step(1'b0, 1'b0, 2, 1'b1);
        check("bp_drain1_valid", count_valid, (DEPTH == 2) ? 1 : 0);
        step(1'b0, 1'b0, 2, 1'b1);
        check("bp_drain2_valid", count_valid, 0);
        check("bp_sticky", dropped, 1);

        // Asynchronous reset mid-window with a pending result.
        step(1'b0, 1'b1, 3, 1'b0);
        repeat (3) step(1'b1, 1'b1, 3, 1'b0);
        check("mid_pre_valid", count_valid, 1);
        step(1'b1, 1'b1, 3, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", count_valid, 0);
        check("mid_rst_data", count_data, 0);
        check("mid_rst_dropped", dropped, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b1, 1'b1, 3, 1'b1);
        repeat (3) step(1'b1, 1'b1, 3, 1'b1);
        check("mid_restart_valid", count_valid, 1);
        check("mid_restart_data", count_data, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic e;
            logic r;
            int   wl;
            s  = ($urandom_range(0, 3) != 0);
            e  = ($urandom_range(0, 9) != 0);
            r  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) wl = 0;
            else if ($urandom_range(0, 7) == 0) wl = int'($urandom_range(16, 40));
            else wl = int'($urandom_range(1, 5));
            step(s, e, wl, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spike_window_counter.md
# spike_window_counter

Downstream stage of the accumulate-and-fire neuron. Counts the neuron's spikes over a programmable window of clock cycles and emits one saturating spike count per window on a valid/ready stream. This turns the neuron's spike train into rate samples for the JTAG readout path. Results are dropped when the consumer stalls, and a sticky flag records each drop.

## Interface
- CNT_WIDTH, 16, width of spike count and of count_data
- WIN_WIDTH, 16, width of win_len (window length in clk cycles)
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- spike_in  input  1  neuron's registered spike flag, not clock-gated; one spike per rising edge it is high
- enable  input  1  run windows while high
- win_len  input  WIN_WIDTH  window length; sampled at each window start; 0 = do not start
- count_data  output  CNT_WIDTH  spike count of a completed window
- count_valid  output  1  count_data holds a result
- count_ready  input  1  consumer accepts; transfer on an edge where valid and ready are both high
- dropped  output  1  sticky; set when a completed result could not be stored

## Operation
- FSM states: IDLE and COUNT.
- IDLE to COUNT: on an edge where enable=1 and win_len≠0. Loads cyc = win_len−1 and spk = 0.
- COUNT, cyc>0: spk = sat(spk + spike_in) and cyc decrements.
- COUNT, cyc=0 (last window edge): the result sat(spk + spike_in) is pushed to the output buffer.
  - If enable=1 and win_len≠0, the next window starts back to back: reload cyc = win_len−1, spk = 0, no gap cycle.
  - Otherwise the FSM goes to IDLE.
- Window coverage: exactly win_len consecutive edges, starting the edge after entry.
- enable low in COUNT before the last edge: partial count is discarded and the FSM goes to IDLE at that edge. Nothing is pushed.
- Saturation: spk clamps at 2^CNT_WIDTH−1 and never wraps.
- win_len changes mid-window are ignored until the next window start.
- Output buffer, single register:
  - Push when empty: stored.
  - Push when full with count_ready=1 on the same edge: old entry leaves, new one is stored.
  - Push when full with count_ready=0: new result discarded and dropped set to 1.
- dropped stays set until reset.
- count_data is stable while count_valid=1 and count_ready=0.

## Timing
- Reset values: count_valid=0, count_data=0, dropped=0, FSM=IDLE, cyc=0, spk=0.
- Reset is asynchronous. Asserting it mid-window or with a pending result clears everything immediately.
- Latency: count_valid rises on the edge that samples the last window cycle, so it is visible in the following cycle.
- A result is presented for at least one cycle.
- count_valid falls on the transfer edge unless a push lands on that same edge.
- Throughput: one result per win_len cycles. The minimum is win_len=1, which gives one result every cycle.
- spike_in is sampled only in COUNT. It is ignored in IDLE.

## Configuration
- SPIKE_WINDOW_SKID_EN defined: the output buffer is a 2-entry FIFO.
  - count_data always shows the oldest entry.
  - Drop only when both entries are occupied and there is no pop on the same edge.
  - Push and pop on the same edge are both honoured at any fill level.
- Not defined: single-register buffer as described above.
- Port list is identical in both builds.

## Structure
- Package spike_window_pkg:
  - state enum {IDLE, COUNT}
  - saturating-increment function, parameterised via width
  - default CNT_WIDTH / WIN_WIDTH constants
- Sub-module spike_result_buf:
  - holds the output buffer: 1-entry register, or 2-entry FIFO under SPIKE_WINDOW_SKID_EN
  - push/data_in, valid/ready/data_out, drop strobe
- Top level holds the FSM, cyc, spk and the dropped flag.

## Test plan
- Reset: hold rst=0 for 3 edges with spike_in=1 and enable=1 → count_valid=0, count_data=0, dropped=0. After release, the first window starts on the first edge.
- Basic count: win_len=8, count_ready=1, spike_in high on window edges 2, 3 and 7 → count_data=3. count_valid is high for one cycle starting after edge 8 of the window. The next window's count is 0 with spike_in held low.
- Saturation: CNT_WIDTH=4, win_len=20, spike_in=1 constantly → count_data=15 with no wrap.
- Backpressure: win_len=2, spike_in=1, count_ready=0.
  - Without macro: first result 2 is held, second is dropped, dropped=1.
  - With SPIKE_WINDOW_SKID_EN: two results held, third dropped.
  - Then count_ready=1 drains in order.
- Abort: win_len=10, drop enable after 5 edges → no result, FSM in IDLE. Re-enable with 3 spikes → count_data=3, no carry-over from the aborted window.
- Reset mid-operation: assert rst while count_valid=1 and cyc≠0 → outputs return to reset values immediately. After release the count restarts from 0.
